// File: rtl/counter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// counter_pkg
// Shared types and constants for the counter seek controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
package counter_pkg;

  localparam int         CNT_W    = 4;
  localparam logic [4:0] MOD_DEC  = 5'd10;
  localparam logic [4:0] MOD_HEX  = 5'd16;
  localparam logic       MODE_HEX = 1'b1;
  localparam logic       MODE_DEC = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_PLAN   = 3'd2,
    ST_RUN    = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/counter_seek_ctrl_seek_distance.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seek_distance
// Combinational shortest-path planner: given the current count, the target
// and the counting modulus, returns direction (1 = up) and step count.
// Revision: 1.0
// ---------------------------------------------------------------------------
module seek_distance
  import counter_pkg::*;
(
  input  logic [CNT_W-1:0] cur,
  input  logic [CNT_W-1:0] target,
  input  logic             mode,
  output logic             dir,
  output logic [CNT_W-1:0] steps,
  output logic             zero
);

  logic [4:0]       modulus;
  logic [4:0]       up_raw;
  logic [4:0]       down_raw;
  logic [CNT_W-1:0] up;
  logic [CNT_W-1:0] down;

  // Modular distances in 5 bits; a borrow into bit 4 means the raw
  // difference went negative, so fold it back by adding the modulus.
  always_comb begin
    modulus  = (mode == MODE_HEX) ? MOD_HEX : MOD_DEC;
    up_raw   = {1'b0, target} - {1'b0, cur};
    down_raw = {1'b0, cur} - {1'b0, target};
    if (up_raw[4]) begin
      up_raw = up_raw + modulus;
    end
    if (down_raw[4]) begin
      down_raw = down_raw + modulus;
    end
    up    = up_raw[CNT_W-1:0];
    down  = down_raw[CNT_W-1:0];
    dir   = (up <= down);
    steps = dir ? up : down;
    zero  = (up == '0);
  end

endmodule
`default_nettype wire

// File: rtl/counter_seek_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// counter_seek_ctrl
// Accepts a seek request, drives an up/down counter to the target value by
// the shortest modular path and reports done/err after checking the result.
// Revision: 1.0
// ---------------------------------------------------------------------------
module counter_seek_ctrl
  import counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_target,
  input  logic             req_mode,
  input  logic [CNT_W-1:0] cnt_value,
  output logic             cnt_clear,
  output logic             cnt_mode,
  output logic             cnt_incr,
  output logic             cnt_enable,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] remain;
  logic             mode_q;
  logic             dir_q;
  logic             reject;
  logic             plan_dir;
  logic [CNT_W-1:0] plan_steps;
  logic             plan_zero;
  logic             report_ok;

  seek_distance u_dist (
    .cur    (cnt_value),
    .target (target_q),
    .mode   (mode_q),
    .dir    (plan_dir),
    .steps  (plan_steps),
    .zero   (plan_zero)
  );

  // Request FSM plus the latched request fields and the step counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      target_q <= '0;
      remain   <= '0;
      mode_q   <= MODE_DEC;
      dir_q    <= 1'b0;
      reject   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            target_q <= req_target;
            mode_q   <= req_mode;
            if (req_mode == MODE_DEC && req_target > 4'd9) begin
              reject <= 1'b1;
              state  <= ST_REPORT;
            end else if (req_mode == MODE_DEC && cnt_value > 4'd9) begin
              // Leftover hex value is outside the decimal range; zero it first.
              state <= ST_CLEAR;
            end else begin
              state <= ST_PLAN;
            end
          end
        end
        ST_CLEAR: begin
          state <= ST_PLAN;
        end
        ST_PLAN: begin
          if (plan_zero) begin
            state <= ST_REPORT;
          end else begin
            dir_q  <= plan_dir;
            remain <= plan_steps;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          remain <= remain - 4'd1;
          if (remain == 4'd1) begin
            state <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          reject <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from the registered state; the verdict in REPORT looks at
  // the live count because the final step lands on the edge entering REPORT.
  always_comb begin
    req_ready  = (state == ST_IDLE);
    busy       = (state != ST_IDLE);
    cnt_clear  = (state == ST_CLEAR);
    cnt_enable = (state == ST_RUN);
    cnt_incr   = dir_q;
    cnt_mode   = mode_q;
    report_ok  = (state == ST_REPORT) && !reject && (cnt_value == target_q);
    done       = report_ok;
    err        = (state == ST_REPORT) && !report_ok;
  end

endmodule
`default_nettype wire
